// File: rtl/engine_filter_cond_control.sv
// Sequencer and credit-based flow controller around the fixed-latency filter-condition kernel.
// Latency: accepted input to out_valid is KERNEL_LATENCY+1 cycles with an empty output FIFO.
// Backpressure: in_ready is withheld unless in-flight results plus FIFO occupancy leave a free slot.
`timescale 1ns/1ps

// Generic first-word-fall-through FIFO with synchronous flush; empty reads return zero.
// Latency: write to rdata_o visibility is one cycle.
// Backpressure: push is ignored when full unless a pop frees a slot in the same cycle.
module engine_filter_cond_control_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Derive effective push/pop and next pointer/count values.
  always_comb begin
    empty_o  = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; flush empties the buffer without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful where the count says so.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

module engine_filter_cond_control #(
  parameter int NUM_FIELDS     = 4,
  parameter int FIELD_W        = 32,
  parameter int KERNEL_LATENCY = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          start,
  input  logic [CNT_W-1:0]              cfg_num_packets,
  input  logic                          cfg_drop_en,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  output logic                          kernel_config_params_valid,
  output logic                          kernel_clear,
  output logic                          kernel_data_valid,
  output logic [NUM_FIELDS*FIELD_W-1:0] kernel_data,
  input  logic                          kernel_result_flag,
  input  logic [NUM_FIELDS*FIELD_W-1:0] kernel_result,
  input  logic                          kernel_result_bool,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
  output logic [CNT_W-1:0]              pass_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          busy,
  output logic                          done,
  output logic                          flag_mismatch
);
  localparam int DW = NUM_FIELDS * FIELD_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          num_q, num_d;
  logic                      drop_en_q, drop_en_d;
  logic [CNT_W-1:0]          issued_q, issued_d;
  logic [CNT_W-1:0]          pass_q, pass_d;
  logic [CNT_W-1:0]          drop_q, drop_d;
  logic                      mism_q, mism_d;
  logic [KERNEL_LATENCY-1:0] dl_q, dl_d;
  logic                      abort_clr_q, abort_clr_d;

  logic          abort_now;
  logic          accept;
  logic          tap;
  logic          keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] inflight;
  logic          credit;

  // Count issued packets still travelling through the kernel.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < KERNEL_LATENCY; i++) begin
      inflight = inflight + CW'(dl_q[i]);
    end
  end

  // A slot is reserved for every in-flight result, so the stall-free return path cannot overflow.
  assign credit    = (inflight + fifo_cnt) < CW'(FIFO_DEPTH);
  assign abort_now = abort & (state_q != S_IDLE);
  assign accept    = in_valid & in_ready;
  assign tap       = dl_q[KERNEL_LATENCY-1];

  // Sequencer next state and control outputs.
  always_comb begin
    state_d                    = state_q;
    in_ready                   = 1'b0;
    kernel_clear               = abort_clr_q;
    kernel_config_params_valid = 1'b0;
    done                       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        kernel_clear = 1'b1;
        state_d      = (cfg_num_packets == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        kernel_config_params_valid = 1'b1;
        in_ready                   = credit & (issued_q < num_q);
        if (issued_q == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        kernel_config_params_valid = 1'b1;
        if ((inflight == '0) && fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_now) state_d = S_IDLE;
  end

  // Datapath next state: delay line, return handling, job counters and mismatch tracking.
  always_comb begin
    keep        = ~(drop_en_q & ~kernel_result_bool);
    fifo_push   = tap & keep & ~abort_now;
    fifo_pop    = out_valid & out_ready;
    num_d       = num_q;
    drop_en_d   = drop_en_q;
    issued_d    = issued_q;
    pass_d      = pass_q;
    drop_d      = drop_q;
    mism_d      = mism_q;
    abort_clr_d = abort_now;
    dl_d        = '0;
    if (!abort_now) begin
      dl_d[0] = accept;
      for (int i = 1; i < KERNEL_LATENCY; i++) begin
        dl_d[i] = dl_q[i-1];
      end
    end
    if (state_q == S_CLEAR) begin
      num_d     = cfg_num_packets;
      drop_en_d = cfg_drop_en;
      issued_d  = '0;
      pass_d    = '0;
      drop_d    = '0;
      mism_d    = 1'b0;
    end else begin
      if (accept && issued_q != CNT_MAX) issued_d = issued_q + CNT_W'(1);
      if (fifo_push && pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
      if (tap && !keep && !abort_now && drop_q != CNT_MAX) drop_d = drop_q + CNT_W'(1);
      if ((state_q == S_RUN || state_q == S_DRAIN) && (tap != kernel_result_flag)) mism_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      drop_en_q   <= 1'b0;
      issued_q    <= '0;
      pass_q      <= '0;
      drop_q      <= '0;
      mism_q      <= 1'b0;
      dl_q        <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      drop_en_q   <= drop_en_d;
      issued_q    <= issued_d;
      pass_q      <= pass_d;
      drop_q      <= drop_d;
      mism_q      <= mism_d;
      dl_q        <= dl_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  engine_filter_cond_control_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i   (ap_clk),
    .rst_i   (areset),
    .flush_i (abort_now),
    .push_i  (fifo_push),
    .wdata_i (kernel_result),
    .pop_i   (fifo_pop),
    .rdata_o (out_data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid         = ~fifo_empty;
  assign kernel_data_valid = accept;
  assign kernel_data       = accept ? in_data : '0;
  assign pass_count        = pass_q;
  assign drop_count        = drop_q;
  assign flag_mismatch     = mism_q;
  assign busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_engine_filter_cond_control.sv
`timescale 1ns/1ps
module tb_engine_filter_cond_control;
  localparam int DW = 128;

  logic          ap_clk, areset, start, cfg_drop_en, abort;
  logic [31:0]   cfg_num_packets;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          kernel_config_params_valid, kernel_clear, kernel_data_valid;
  logic [DW-1:0] kernel_data;
  logic          kernel_result_flag, kernel_result_bool;
  logic [DW-1:0] kernel_result;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   pass_count, drop_count;
  logic          busy, done, flag_mismatch;

  engine_filter_cond_control dut (
    .ap_clk(ap_clk), .areset(areset), .start(start), .cfg_num_packets(cfg_num_packets),
    .cfg_drop_en(cfg_drop_en), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .kernel_config_params_valid(kernel_config_params_valid),
    .kernel_clear(kernel_clear), .kernel_data_valid(kernel_data_valid), .kernel_data(kernel_data),
    .kernel_result_flag(kernel_result_flag), .kernel_result(kernel_result),
    .kernel_result_bool(kernel_result_bool), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .pass_count(pass_count), .drop_count(drop_count), .busy(busy),
    .done(done), .flag_mismatch(flag_mismatch)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Kernel model: three-stage pipeline, verdict is bit 0 of the packet, flag can be suppressed.
  logic          kflag_en;
  logic [2:0]    kv;
  logic [DW-1:0] kd [3];
  always @(posedge ap_clk or posedge areset) begin
    if (areset) kv <= '0;
    else if (kernel_clear) kv <= '0;
    else begin
      kv    <= {kv[1:0], kernel_data_valid};
      kd[0] <= kernel_data;
      kd[1] <= kd[0];
      kd[2] <= kd[1];
    end
  end
  assign kernel_result_flag = kv[2] & kflag_en;
  assign kernel_result      = kd[2];
  assign kernel_result_bool = kd[2][0];

  // Monitor: cycle stamps of accepts, pops, start and done.
  int            cyc = 0, done_cnt = 0, done_cyc = 0, st_cyc = 0, ir_cnt = 0;
  int            acc_cyc[$], pop_cyc[$];
  logic [DW-1:0] out_q[$];
  always @(posedge ap_clk) begin
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      pop_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (start) st_cyc = cyc;
    if (in_ready) ir_cnt = ir_cnt + 1;
    cyc = cyc + 1;
  end

  int n_total = 0, n_bad = 0;
  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] stim[$];

  function automatic logic [DW-1:0] pkt(input int i, input bit b);
    logic [31:0] t;
    t = 32'(i * 2) | {31'b0, b};
    return {32'hA000_0000 | t, 32'hB000_0000 | t, 32'hC000_0000 | t, 32'hD000_0000 | t};
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit drop);
    cfg_num_packets = 32'(n);
    cfg_drop_en     = drop;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  task automatic feed(input int first, input int n, input int max_cyc, output int got);
    int  c;
    logic acc;
    got = 0;
    c   = 0;
    while (got < n && c < max_cyc) begin
      in_valid = 1'b1;
      in_data  = stim[first + got];
      acc      = in_ready;
      tick();
      if (acc) got++;
      c++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    check_val("idle_timeout", {127'b0, busy}, 0);
  endtask

  int got, got2, a0, o0, d0, i0;

  initial begin
    areset = 1'b1; start = 1'b0; cfg_num_packets = '0; cfg_drop_en = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; kflag_en = 1'b1;
    tick(); tick();
    check_val("rst_busy", {127'b0, busy}, 0);
    check_val("rst_out_valid", {127'b0, out_valid}, 0);
    check_val("rst_in_ready", {127'b0, in_ready}, 0);
    check_val("rst_kclear", {127'b0, kernel_clear}, 0);
    check_val("rst_pass", {96'b0, pass_count}, 0);
    areset = 1'b0;
    tick();

    // Pass-through job, four packets.
    out_ready = 1'b1;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(pkt(i, 1'b1));
    a0 = acc_cyc.size(); o0 = out_q.size(); d0 = done_cnt;
    do_start(4, 1'b0);
    feed(0, 4, 30, got);
    check_val("pt_accepted", 128'(got), 4);
    check_val("pt_cfg_valid", {127'b0, kernel_config_params_valid}, 1);
    wait_idle(50);
    check_val("pt_out_count", 128'(out_q.size() - o0), 4);
    for (int i = 0; i < 4; i++) begin
      if (out_q.size() > o0 + i) begin
        check_val("pt_data", out_q[o0 + i], stim[i]);
        check_val("pt_latency", 128'(pop_cyc[o0 + i] - acc_cyc[a0 + i]), 4);
      end
    end
    check_val("pt_pass", {96'b0, pass_count}, 4);
    check_val("pt_drop", {96'b0, drop_count}, 0);
    check_val("pt_done_once", 128'(done_cnt - d0), 1);
    check_val("pt_done_after_pop", {127'b0, done_cyc > pop_cyc[pop_cyc.size() - 1]}, 1);

    // Drop job: verdicts 1,0,1,0,0,1 keep packets 0, 2 and 5.
    stim.delete();
    stim.push_back(pkt(0, 1)); stim.push_back(pkt(1, 0)); stim.push_back(pkt(2, 1));
    stim.push_back(pkt(3, 0)); stim.push_back(pkt(4, 0)); stim.push_back(pkt(5, 1));
    o0 = out_q.size(); d0 = done_cnt;
    do_start(6, 1'b1);
    feed(0, 6, 30, got);
    wait_idle(50);
    check_val("drop_out_count", 128'(out_q.size() - o0), 3);
    if (out_q.size() >= o0 + 3) begin
      check_val("drop_data0", out_q[o0],     pkt(0, 1));
      check_val("drop_data1", out_q[o0 + 1], pkt(2, 1));
      check_val("drop_data2", out_q[o0 + 2], pkt(5, 1));
    end
    check_val("drop_pass", {96'b0, pass_count}, 3);
    check_val("drop_drop", {96'b0, drop_count}, 3);
    check_val("drop_done", 128'(done_cnt - d0), 1);

    // Backpressure: twelve packets against an eight-entry buffer.
    out_ready = 1'b0;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(pkt(40 + i, 1'b1));
    o0 = out_q.size();
    do_start(12, 1'b0);
    feed(0, 12, 25, got);
    check_val("bp_stall_accepts", 128'(got), 8);
    check_val("bp_in_ready_low", {127'b0, in_ready}, 0);
    check_val("bp_pass_full", {96'b0, pass_count}, 8);
    out_ready = 1'b1;
    feed(8, 4, 40, got2);
    check_val("bp_rest_accepts", 128'(got2), 4);
    wait_idle(60);
    check_val("bp_out_count", 128'(out_q.size() - o0), 12);
    for (int i = 0; i < 12; i++) begin
      if (out_q.size() > o0 + i) check_val("bp_data", out_q[o0 + i], pkt(40 + i, 1'b1));
    end

    // Zero-length job.
    d0 = done_cnt; i0 = ir_cnt;
    do_start(0, 1'b0);
    wait_idle(10);
    check_val("zero_done", 128'(done_cnt - d0), 1);
    check_val("zero_done_delay", 128'(done_cyc - st_cyc), 2);
    check_val("zero_in_ready", 128'(ir_cnt - i0), 0);

    // Abort with two packets in flight and one buffered.
    out_ready = 1'b0;
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(pkt(60 + i, 1'b1));
    do_start(5, 1'b0);
    feed(0, 3, 10, got);
    check_val("ab_accepts", 128'(got), 3);
    tick();
    check_val("ab_pre_valid", {127'b0, out_valid}, 1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab_busy", {127'b0, busy}, 0);
    check_val("ab_out_valid", {127'b0, out_valid}, 0);
    check_val("ab_kclear", {127'b0, kernel_clear}, 1);
    check_val("ab_pass_hold", {96'b0, pass_count}, 1);
    tick();
    check_val("ab_kclear_once", {127'b0, kernel_clear}, 0);
    check_val("ab_no_done", 128'(done_cnt - d0), 0);
    tick(); tick();
    out_ready = 1'b1;
    stim.delete();
    stim.push_back(pkt(80, 1'b1)); stim.push_back(pkt(81, 1'b1));
    o0 = out_q.size(); d0 = done_cnt;
    do_start(2, 1'b0);
    feed(0, 2, 20, got);
    wait_idle(40);
    check_val("ab_rerun_count", 128'(out_q.size() - o0), 2);
    if (out_q.size() >= o0 + 2) begin
      check_val("ab_rerun_d0", out_q[o0],     pkt(80, 1'b1));
      check_val("ab_rerun_d1", out_q[o0 + 1], pkt(81, 1'b1));
    end
    check_val("ab_rerun_done", 128'(done_cnt - d0), 1);
    check_val("ab_rerun_mism", {127'b0, flag_mismatch}, 0);

    // Kernel flag withheld: mismatch flagged, packet still delivered.
    kflag_en = 1'b0;
    stim.delete();
    stim.push_back(pkt(90, 1'b1)); stim.push_back(pkt(91, 1'b1)); stim.push_back(pkt(92, 1'b1));
    o0 = out_q.size();
    do_start(1, 1'b0);
    feed(0, 1, 20, got);
    wait_idle(40);
    check_val("mm_flag", {127'b0, flag_mismatch}, 1);
    check_val("mm_out_count", 128'(out_q.size() - o0), 1);
    if (out_q.size() > o0) check_val("mm_data", out_q[o0], pkt(90, 1'b1));

    // Asynchronous reset in the middle of a job.
    do_start(3, 1'b0);
    feed(1, 2, 20, got);
    tick(); tick(); tick(); tick();
    check_val("ar_pre_busy", {127'b0, busy}, 1);
    check_val("ar_pre_pass", {96'b0, pass_count}, 2);
    check_val("ar_pre_mism", {127'b0, flag_mismatch}, 1);
    areset = 1'b1;
    #2;
    check_val("ar_busy", {127'b0, busy}, 0);
    check_val("ar_pass", {96'b0, pass_count}, 0);
    check_val("ar_mism", {127'b0, flag_mismatch}, 0);
    check_val("ar_cfg_valid", {127'b0, kernel_config_params_valid}, 0);
    check_val("ar_in_ready", {127'b0, in_ready}, 0);
    check_val("ar_out_valid", {127'b0, out_valid}, 0);
    check_val("ar_out_data", out_data, 0);
    tick(); tick();
    areset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
